// File: rtl/ic_pkg.sv
// ic_pkg: shared types, constants and MAC schedule lookup for the intersection core.
package ic_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, CALC, WB} state_t;
   localparam int FRAC_BITS = 16;
   localparam logic [31:0] EPS_DEFAULT = 32'h0000_0010;
   localparam logic [3:0] LAST_STEP = 4'd14;
   // Operand indices: dir 0-2, tvec 3-5, v0v1 6-8, v0v2 9-11, pvec 12-14; dst: pvec 0-2, qvec 3-5, det 6.
   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic sub;
      logic fin;
      logic [2:0] dst;
   } op_t;
   function automatic logic [31:0] vx(input logic [95:0] v);
      return v[95:64];
   endfunction
   function automatic logic [31:0] vy(input logic [95:0] v);
      return v[63:32];
   endfunction
   function automatic logic [31:0] vz(input logic [95:0] v);
      return v[31:0];
   endfunction
   function automatic op_t step_op(input logic [3:0] s);
      op_t o;
      logic [2:0] h;
      logic [1:0] c, c1, c2, k;
      h = s[3:1];
      c = (h >= 3'd3) ? 2'(h - 3'd3) : h[1:0];
      c1 = (c == 2'd2) ? 2'd0 : c + 2'd1;
      c2 = (c == 2'd0) ? 2'd2 : c - 2'd1;
      k = 2'(s - 4'd12);
      if (s >= 4'd12)
         o = '{a: 4'd6 + {2'b0, k}, b: 4'd12 + {2'b0, k}, sub: 1'b0, fin: s == LAST_STEP, dst: 3'd6};
      else
         o = '{a: (s < 4'd6 ? 4'd0 : 4'd3) + {2'b0, s[0] ? c2 : c1},
               b: (s < 4'd6 ? 4'd9 : 4'd6) + {2'b0, s[0] ? c1 : c2},
               sub: s[0], fin: s[0], dst: h};
      return o;
   endfunction
endpackage

// File: rtl/ic_mac_q16.sv
// ic_mac_q16: signed Q16.16 multiply-accumulate with 64-bit wrapping accumulator.
module ic_mac_q16
   import ic_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        sub,
   input  logic        clr,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] res
);
   logic signed [63:0] acc, prod, sum;
   assign prod = 64'($signed(a)) * 64'($signed(b));
   assign sum = sub ? acc - prod : acc + prod;
   assign res = sum[FRAC_BITS+31:FRAC_BITS];
   always_ff @(posedge clk or posedge rst)
      if (rst) acc <= '0;
      else if (en) acc <= clr ? '0 : sum;
endmodule

// File: rtl/ic_stage2.sv
// ic_stage2: Moller-Trumbore stage II (pvec, qvec, det) on one time-shared MAC.
// IC_STAGE2_PARALLEL_EN enables the registered near-parallel miss flag.
module ic_stage2
   import ic_pkg::*;
#(
   parameter logic [31:0] EPS = EPS_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StageI_capture,
   input  logic        StageIII_capture,
   input  logic [31:0] sid_in,
   input  logic [95:0] v0v1_in,
   input  logic [95:0] v0v2_in,
   input  logic [95:0] dir_in,
   input  logic [95:0] tvec_in,
   output logic        StageII_capture,
   output logic        StageII_done,
   output logic [31:0] sid_out,
   output logic [95:0] dir_out,
   output logic [95:0] v0v2_out,
   output logic [95:0] tvec_out,
   output logic [95:0] pvec_out,
   output logic [95:0] qvec_out,
   output logic [31:0] det_out,
   output logic        miss_out
);
   state_t state, state_nx;
   logic avail, res_full, load, wb, fin;
   logic [3:0] step;
   logic [31:0] sid_w, mac_res;
   logic [95:0] dir_w, v0v1_w, v0v2_w, tvec_w;
   logic [31:0] res_w [7];
   logic [31:0] ops [16];
   op_t op;
   assign op = step_op(step);
   assign ops = '{vx(dir_w), vy(dir_w), vz(dir_w), vx(tvec_w), vy(tvec_w), vz(tvec_w),
                  vx(v0v1_w), vy(v0v1_w), vz(v0v1_w), vx(v0v2_w), vy(v0v2_w), vz(v0v2_w),
                  res_w[0], res_w[1], res_w[2], 32'd0};
   assign load = state == IDLE && (StageI_capture || avail);
   assign fin = state == CALC && op.fin;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state == IDLE ? (load ? LOAD : IDLE) :
                 state == LOAD ? CALC :
                 state == CALC ? (step == LAST_STEP ? WB : CALC) :
                 (wb ? IDLE : WB);
   end
   always_comb begin
      StageII_capture = state == LOAD;
      wb = state == WB && (!res_full || StageIII_capture);
      StageII_done = wb;
   end
   ic_mac_q16 u_mac (
      .clk(clk), .rst(rst), .en(state == CALC), .sub(op.sub), .clr(op.fin),
      .a(ops[op.a]), .b(ops[op.b]), .res(mac_res)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         avail <= 1'b0;
         res_full <= 1'b0;
         step <= '0;
         sid_w <= '0;
         dir_w <= '0;
         v0v1_w <= '0;
         v0v2_w <= '0;
         tvec_w <= '0;
         res_w <= '{default: '0};
      end else begin
         avail <= !load && (avail || StageI_capture);
         res_full <= wb || (res_full && !StageIII_capture);
         step <= state == CALC ? step + 4'd1 : 4'd0;
         if (load) begin
            sid_w <= sid_in;
            dir_w <= dir_in;
            v0v1_w <= v0v1_in;
            v0v2_w <= v0v2_in;
            tvec_w <= tvec_in;
         end
         if (fin) res_w[op.dst] <= mac_res;
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sid_out <= '0;
         dir_out <= '0;
         v0v2_out <= '0;
         tvec_out <= '0;
         pvec_out <= '0;
         qvec_out <= '0;
         det_out <= '0;
      end else if (wb) begin
         sid_out <= sid_w;
         dir_out <= dir_w;
         v0v2_out <= v0v2_w;
         tvec_out <= tvec_w;
         pvec_out <= {res_w[0], res_w[1], res_w[2]};
         qvec_out <= {res_w[3], res_w[4], res_w[5]};
         det_out <= res_w[6];
      end
`ifdef IC_STAGE2_PARALLEL_EN
   logic [31:0] det_mag;
   assign det_mag = res_w[6][31] ? -res_w[6] : res_w[6];
   always_ff @(posedge clk or posedge rst)
      if (rst) miss_out <= 1'b0;
      else if (wb) miss_out <= det_mag < EPS;
`else
   logic unused_eps;
   assign unused_eps = ^EPS;
   assign miss_out = 1'b0;
`endif
endmodule
